// File: rtl/rgb2ycbcr_cfg.sv
// rtl/rgb2ycbcr_cfg.sv - configurable RGB to YCbCr converter with 3-stage pipeline
//
// Purpose: converts an unsigned RGB pixel stream to YCbCr (BT.601 / BT.709
// full-range), grayscale or bypass. The mode is sampled on the vsync rising
// edge so that it only changes between frames. Fixed 3-cycle latency; the
// pipeline never stalls.
//
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   per_img_vsync/herf/valid          input frame sync, line reference, pixel valid
//   per_img_red/green/blue [DW]       input pixel
//   mode_cfg [2]                      requested mode (0 601, 1 709, 2 gray, 3 bypass)
//   post_img_vsync/herf/valid         syncs delayed 3 cycles
//   post_img_Y/Cb/Cr [DW]             converted pixel (held between valid pixels)
//   mode_active [2]                   mode latched at the last vsync rising edge
module rgb2ycbcr_cfg #(
  parameter int         DW        = 8,
  parameter logic [1:0] MODE_INIT = 2'd0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          per_img_vsync,
  input  logic          per_img_herf,
  input  logic          per_img_valid,
  input  logic [DW-1:0] per_img_red,
  input  logic [DW-1:0] per_img_green,
  input  logic [DW-1:0] per_img_blue,
  input  logic [1:0]    mode_cfg,
  output logic          post_img_vsync,
  output logic          post_img_herf,
  output logic          post_img_valid,
  output logic [DW-1:0] post_img_Y,
  output logic [DW-1:0] post_img_Cb,
  output logic [DW-1:0] post_img_Cr,
  output logic [1:0]    mode_active
);

  localparam int SW = DW + 11;
  localparam logic signed [SW-1:0] OFF  = SW'((2 ** (DW - 1)) * 256 + 128);
  localparam logic signed [SW-1:0] RND  = SW'(128);
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** DW) - 1);

  typedef logic signed [8:0] coef_t;
  // Order: Y(R,G,B), Cb(R,G,B), Cr(R,G,B)
  localparam coef_t C601 [9] = '{9'sd77, 9'sd150, 9'sd29,
                                 -9'sd43, -9'sd85, 9'sd128,
                                 9'sd128, -9'sd107, -9'sd21};
  localparam coef_t C709 [9] = '{9'sd54, 9'sd183, 9'sd19,
                                 -9'sd29, -9'sd99, 9'sd128,
                                 9'sd128, -9'sd116, -9'sd12};

  // Sync delay chain; bit 0 = stage1, bit 2 = output stage
  logic [2:0] vs_q, hf_q, vd_q;

  logic [1:0] mode_q, mode_d;
  logic       vsync_rise;

  // Stage1 registers
  logic signed [SW-1:0] prod_q [9];
  logic signed [SW-1:0] prod_d [9];
  logic signed [SW-1:0] chan_s [3];
  logic [DW-1:0]        raw_r_q, raw_g_q, raw_b_q;
  logic [1:0]           tag1_q;
  coef_t                coef;

  // Stage2 registers
  logic signed [SW-1:0] sum_y_q, sum_cb_q, sum_cr_q;
  logic signed [SW-1:0] sum_y_d, sum_cb_d, sum_cr_d;

  // Stage3 (output) registers
  logic [DW-1:0] y_q, cb_q, cr_q;

  // vs_q[0] is last cycle's vsync, so it doubles as the edge detector
  assign vsync_rise = per_img_vsync & ~vs_q[0];
  assign mode_d     = vsync_rise ? mode_cfg : mode_q;

  always_comb begin
    coef      = '0;
    chan_s[0] = $signed({{(SW-DW){1'b0}}, per_img_red});
    chan_s[1] = $signed({{(SW-DW){1'b0}}, per_img_green});
    chan_s[2] = $signed({{(SW-DW){1'b0}}, per_img_blue});
    for (int k = 0; k < 9; k++) begin
      coef      = (mode_q == 2'd1) ? C709[k] : C601[k];
      prod_d[k] = chan_s[k % 3] * $signed({{(SW-9){coef[8]}}, coef});
    end
  end

  always_comb begin
    sum_y_d  = prod_q[0] + prod_q[1] + prod_q[2] + RND;
    sum_cb_d = prod_q[3] + prod_q[4] + prod_q[5] + OFF;
    sum_cr_d = prod_q[6] + prod_q[7] + prod_q[8] + OFF;
    case (tag1_q)
      2'd2: begin
        // OFF >> 8 is exactly the chroma midpoint
        sum_cb_d = OFF;
        sum_cr_d = OFF;
      end
      2'd3: begin
        // Pre-scale raw channels so the common >>8 in stage3 returns them unchanged
        sum_y_d  = $signed({{(SW-DW-8){1'b0}}, raw_r_q, 8'h00});
        sum_cb_d = $signed({{(SW-DW-8){1'b0}}, raw_g_q, 8'h00});
        sum_cr_d = $signed({{(SW-DW-8){1'b0}}, raw_b_q, 8'h00});
      end
      default: ;
    endcase
  end

  function automatic logic [DW-1:0] clamp_px(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] sh;
    sh = s >>> 8;
    if (sh[SW-1])        clamp_px = '0;
    else if (sh > MAXV)  clamp_px = '1;
    else                 clamp_px = sh[DW-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q     <= '0;
      hf_q     <= '0;
      vd_q     <= '0;
      mode_q   <= MODE_INIT;
      for (int k = 0; k < 9; k++) prod_q[k] <= '0;
      raw_r_q  <= '0;
      raw_g_q  <= '0;
      raw_b_q  <= '0;
      tag1_q   <= '0;
      sum_y_q  <= '0;
      sum_cb_q <= '0;
      sum_cr_q <= '0;
      y_q      <= '0;
      cb_q     <= '0;
      cr_q     <= '0;
    end else begin
      vs_q     <= {vs_q[1:0], per_img_vsync};
      hf_q     <= {hf_q[1:0], per_img_herf};
      vd_q     <= {vd_q[1:0], per_img_valid};
      mode_q   <= mode_d;
      for (int k = 0; k < 9; k++) prod_q[k] <= prod_d[k];
      raw_r_q  <= per_img_red;
      raw_g_q  <= per_img_green;
      raw_b_q  <= per_img_blue;
      // Pixel carries the mode in force when it enters, not the one being latched now
      tag1_q   <= mode_q;
      sum_y_q  <= sum_y_d;
      sum_cb_q <= sum_cb_d;
      sum_cr_q <= sum_cr_d;
      // Load only real pixels so outputs hold across valid gaps
      if (vd_q[1]) begin
        y_q  <= clamp_px(sum_y_q);
        cb_q <= clamp_px(sum_cb_q);
        cr_q <= clamp_px(sum_cr_q);
      end
    end
  end

  assign post_img_vsync = vs_q[2];
  assign post_img_herf  = hf_q[2];
  assign post_img_valid = vd_q[2];
  assign post_img_Y     = y_q;
  assign post_img_Cb    = cb_q;
  assign post_img_Cr    = cr_q;
  assign mode_active    = mode_q;

endmodule
